// File: rtl/microcode_sequencer_if.sv
// Bus between the microcode sequencer and its surroundings: opcode handshake, interrupt requests,
// table write port and the registered decode outputs.
interface microcode_sequencer_if #(
    parameter int unsigned OPC_W  = 8,
    parameter int unsigned STEP_W = 3,
    parameter int unsigned CW_W   = 63
);
    logic                    clock_running;
    logic [OPC_W-1:0]        opcode;
    logic                    opcode_valid;
    logic                    nmi_req;
    logic                    irq_req;
    logic                    irq_mask;
    logic                    ucode_we;
    logic [OPC_W+STEP_W-1:0] ucode_waddr;
    logic [CW_W:0]           ucode_wdata;

    logic [CW_W-1:0]         ctrl_word;
    logic [STEP_W-1:0]       step_count;
    logic                    instr_done;
    logic                    fetch_wait;
    logic [4:0]              vector_operations;
    logic                    ucode_err;

    modport master (
        output clock_running, opcode, opcode_valid, nmi_req, irq_req, irq_mask,
               ucode_we, ucode_waddr, ucode_wdata,
        input  ctrl_word, step_count, instr_done, fetch_wait, vector_operations, ucode_err
    );

    modport slave (
        input  clock_running, opcode, opcode_valid, nmi_req, irq_req, irq_mask,
               ucode_we, ucode_waddr, ucode_wdata,
        output ctrl_word, step_count, instr_done, fetch_wait, vector_operations, ucode_err
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Table-driven microcode sequencer: issues one registered control word per enabled fclk from a
// writable {page, step} table, handling reset/NMI/IRQ entry pages and opcode fetch.
module microcode_sequencer #(
    parameter int unsigned      OPC_W    = 8,
    parameter int unsigned      STEP_W   = 3,
    parameter int unsigned      CW_W     = 63,
    parameter logic [OPC_W-1:0] RST_PAGE = OPC_W'(0),
    parameter logic [OPC_W-1:0] NMI_PAGE = OPC_W'(1),
    parameter logic [OPC_W-1:0] IRQ_PAGE = OPC_W'(2)
) (
    input logic                   fclk,
    input logic                   reset,
    microcode_sequencer_if.slave  bus
);
    localparam int unsigned ADDR_W    = OPC_W + STEP_W;
    localparam int unsigned MAX_STEPS = 2 ** STEP_W;

    typedef enum logic {
        S_RUN,
        S_FETCH
    } state_t;

    logic [CW_W:0]      ucode_table [0:(2**ADDR_W)-1];

    state_t             state;
    logic [OPC_W-1:0]   page;
    logic [STEP_W-1:0]  step;
    logic               nmi_prev;
    logic               nmi_pending;
    logic [CW_W-1:0]    ctrl_word_q;
    logic               instr_done_q;
    logic               ucode_err_q;
    logic [4:0]         vector_q;

    logic [CW_W:0]      entry;
    logic               last_flag;
    logic               end_of_page;
    logic               nmi_edge;

    // Table is plain storage: never cleared, writable in any state, read-old-data on collisions.
    always_ff @(posedge fclk) begin
        if (bus.ucode_we) begin
            ucode_table[bus.ucode_waddr] <= bus.ucode_wdata;
        end
    end

    assign entry       = ucode_table[{page, step}];
    assign last_flag   = entry[CW_W];
    assign end_of_page = last_flag || (step == STEP_W'(MAX_STEPS - 1));
    assign nmi_edge    = bus.nmi_req && !nmi_prev;

    // nmi_prev tracks the pin even through reset so a level held across reset is not a new edge.
    always_ff @(posedge fclk) begin
        nmi_prev <= bus.nmi_req;
        if (reset) begin
            state        <= S_RUN;
            page         <= RST_PAGE;
            step         <= '0;
            ctrl_word_q  <= '0;
            instr_done_q <= 1'b0;
            ucode_err_q  <= 1'b0;
            nmi_pending  <= 1'b0;
            vector_q     <= 5'b11000;
        end else begin
            ctrl_word_q  <= '0;
            instr_done_q <= 1'b0;
            if (nmi_edge) begin
                nmi_pending <= 1'b1;
            end
            if (bus.clock_running) begin
                case (state)
                    S_RUN: begin
                        ctrl_word_q <= entry[CW_W-1:0];
                        if (end_of_page) begin
                            instr_done_q <= 1'b1;
                            step         <= '0;
                            if (!last_flag) begin
                                ucode_err_q <= 1'b1;
                            end
                            // An edge arriving while the pending NMI is consumed stays pending.
                            if (nmi_pending) begin
                                page        <= NMI_PAGE;
                                vector_q    <= 5'b10100;
                                nmi_pending <= nmi_edge;
                            end else if (bus.irq_req && !bus.irq_mask) begin
                                page     <= IRQ_PAGE;
                                vector_q <= 5'b10010;
                            end else begin
                                state    <= S_FETCH;
                                vector_q <= 5'b00000;
                            end
                        end else begin
                            step <= step + STEP_W'(1);
                        end
                    end
                    S_FETCH: begin
                        if (bus.opcode_valid) begin
                            page  <= bus.opcode;
                            step  <= '0;
                            state <= S_RUN;
                        end
                    end
                    default: state <= S_RUN;
                endcase
            end
        end
    end

    assign bus.ctrl_word         = ctrl_word_q;
    assign bus.step_count        = step;
    assign bus.instr_done        = instr_done_q;
    assign bus.fetch_wait        = (state == S_FETCH);
    assign bus.vector_operations = vector_q;
    assign bus.ucode_err         = ucode_err_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a page-level queue model.
module tb_microcode_sequencer;
    localparam int unsigned OPC_W  = 8;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned CW_W   = 63;
    localparam int unsigned ADDR_W = OPC_W + STEP_W;

    logic fclk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   fails = 0;

    microcode_sequencer_if #(.OPC_W(OPC_W), .STEP_W(STEP_W), .CW_W(CW_W)) bus ();

    microcode_sequencer #(
        .OPC_W(OPC_W), .STEP_W(STEP_W), .CW_W(CW_W),
        .RST_PAGE(8'h00), .NMI_PAGE(8'h01), .IRQ_PAGE(8'h02)
    ) dut (
        .fclk (fclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 fclk = ~fclk;

    // Model: each page is expanded into the list of words it will issue when it first runs.
    bit   [CW_W:0]     model_tbl [0:(2**ADDR_W)-1];
    logic [CW_W-1:0]   m_q [$];
    bit                m_valid = 1'b0;
    bit                m_fetch, m_need_build, m_overrun, m_pending, m_prev;
    logic [OPC_W-1:0]  m_page;
    int                m_issued;
    logic [CW_W-1:0]   e_ctrl;
    logic [STEP_W-1:0] e_step;
    bit                e_done, e_err;
    logic [4:0]        e_vec;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void startPage(input logic [OPC_W-1:0] p);
        m_page       = p;
        m_need_build = 1'b1;
        m_issued     = 0;
        m_q.delete();
    endfunction

    function automatic void buildPage();
        bit [CW_W:0] w;
        m_overrun = 1'b1;
        for (int s = 0; s < 2**STEP_W; s++) begin
            w = model_tbl[{m_page, STEP_W'(s)}];
            m_q.push_back(w[CW_W-1:0]);
            if (w[CW_W]) begin
                m_overrun = 1'b0;
                break;
            end
        end
        m_need_build = 1'b0;
    endfunction

    always @(posedge fclk) begin
        bit nmi_edge;
        nmi_edge = bus.nmi_req && !m_prev;
        if (reset) begin
            m_valid   = 1'b1;
            m_fetch   = 1'b0;
            m_pending = 1'b0;
            startPage(8'h00);
            e_ctrl = '0; e_step = '0; e_done = 1'b0; e_err = 1'b0; e_vec = 5'b11000;
        end else begin
            e_ctrl = '0;
            e_done = 1'b0;
            if (bus.clock_running && !m_fetch) begin
                if (m_need_build) buildPage();
                e_ctrl = m_q.pop_front();
                m_issued++;
                e_step = STEP_W'(m_issued);
                if (m_q.size() == 0) begin
                    e_done = 1'b1;
                    e_step = '0;
                    if (m_overrun) e_err = 1'b1;
                    if (m_pending) begin
                        startPage(8'h01);
                        e_vec     = 5'b10100;
                        m_pending = 1'b0;
                    end else if (bus.irq_req && !bus.irq_mask) begin
                        startPage(8'h02);
                        e_vec = 5'b10010;
                    end else begin
                        m_fetch = 1'b1;
                        e_vec   = 5'b00000;
                    end
                end
            end else if (bus.clock_running && m_fetch && bus.opcode_valid) begin
                m_fetch = 1'b0;
                startPage(bus.opcode);
                e_step = '0;
            end
            if (nmi_edge) m_pending = 1'b1;
        end
        m_prev = bus.nmi_req;
        if (bus.ucode_we) model_tbl[bus.ucode_waddr] = bus.ucode_wdata;
    end

    always @(negedge fclk) begin
        if (m_valid) begin
            checkOutput("ctrl_word", 64'(bus.ctrl_word), 64'(e_ctrl));
            checkOutput("step_count", 64'(bus.step_count), 64'(e_step));
            checkOutput("instr_done", 64'(bus.instr_done), 64'(e_done));
            checkOutput("fetch_wait", 64'(bus.fetch_wait), 64'(m_fetch));
            checkOutput("vector_operations", 64'(bus.vector_operations), 64'(e_vec));
            checkOutput("ucode_err", 64'(bus.ucode_err), 64'(e_err));
        end
    end

    task automatic applyStimulus(input bit rst, input bit run, input bit valid, input logic [7:0] opc,
                                 input bit nmi, input bit irq, input bit mask);
        @(negedge fclk);
        reset             = rst;
        bus.clock_running = run;
        bus.opcode_valid  = valid;
        bus.opcode        = opc;
        bus.nmi_req       = nmi;
        bus.irq_req       = irq;
        bus.irq_mask      = mask;
        @(posedge fclk);
        #1;
    endtask

    task automatic loadWord(input logic [7:0] page, input int s, input bit last, input logic [CW_W-1:0] cw);
        @(negedge fclk);
        bus.ucode_we    = 1'b1;
        bus.ucode_waddr = {page, STEP_W'(s)};
        bus.ucode_wdata = {last, cw};
        @(posedge fclk);
        #1;
        bus.ucode_we = 1'b0;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        bit nmi_lvl, irq_lvl;
        reset = 1'b1;
        bus.clock_running = 1'b0; bus.opcode_valid = 1'b0; bus.opcode = '0;
        bus.nmi_req = 1'b0; bus.irq_req = 1'b0; bus.irq_mask = 1'b0;
        bus.ucode_we = 1'b0; bus.ucode_waddr = '0; bus.ucode_wdata = '0;
        repeat (2) @(posedge fclk);
        #1;
        checkOutput("rst ctrl_word", 64'(bus.ctrl_word), 64'h0);
        checkOutput("rst step", 64'(bus.step_count), 64'h0);
        checkOutput("rst vector", 64'(bus.vector_operations), 64'b11000);
        checkOutput("rst err", 64'(bus.ucode_err), 64'h0);
        checkOutput("rst fetch_wait", 64'(bus.fetch_wait), 64'h0);

        // Table is loaded while stalled so the reset page has not started yet.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 2**ADDR_W; a++) begin
            r = {$urandom, $urandom};
            loadWord(8'(a >> STEP_W), a % (2**STEP_W), ($urandom_range(0, 3) == 0), r[CW_W-1:0]);
        end
        loadWord(8'h00, 0, 1'b0, 63'h1);
        loadWord(8'h00, 1, 1'b1, 63'h2);
        loadWord(8'hA9, 0, 1'b0, 63'h10);
        loadWord(8'hA9, 1, 1'b0, 63'h11);
        loadWord(8'hA9, 2, 1'b1, 63'h12);
        loadWord(8'h01, 0, 1'b0, 63'h20);
        loadWord(8'h01, 1, 1'b1, 63'h21);
        loadWord(8'h02, 0, 1'b1, 63'h30);
        for (int s = 0; s < 8; s++) loadWord(8'h33, s, 1'b0, 63'(8'h40 + s));
        checkOutput("stall step", 64'(bus.step_count), 64'h0);

        runIdle(1);
        checkOutput("rst page w0", 64'(bus.ctrl_word), 64'h1);
        runIdle(1);
        checkOutput("rst page w1", 64'(bus.ctrl_word), 64'h2);
        checkOutput("rst page done", 64'(bus.instr_done), 64'h1);
        runIdle(1);
        checkOutput("fetch ctrl", 64'(bus.ctrl_word), 64'h0);
        checkOutput("fetch_wait", 64'(bus.fetch_wait), 64'h1);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA9, 1'b0, 1'b0, 1'b0);
        checkOutput("accept ctrl", 64'(bus.ctrl_word), 64'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("A9 w0", 64'(bus.ctrl_word), 64'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("A9 w1", 64'(bus.ctrl_word), 64'h11);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("A9 w2", 64'(bus.ctrl_word), 64'h12);
        checkOutput("nmi vector", 64'(bus.vector_operations), 64'b10100);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("nmi w0", 64'(bus.ctrl_word), 64'h20);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("nmi w1", 64'(bus.ctrl_word), 64'h21);
        checkOutput("irq vector", 64'(bus.vector_operations), 64'b10010);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("irq w0", 64'(bus.ctrl_word), 64'h30);
        checkOutput("irq end vector", 64'(bus.vector_operations), 64'b00000);

        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA9, 1'b0, 1'b0, 1'b0);
        runIdle(1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checkOutput("stall ctrl", 64'(bus.ctrl_word), 64'h0);
            checkOutput("stall step", 64'(bus.step_count), 64'h1);
        end
        runIdle(1);
        checkOutput("resume word", 64'(bus.ctrl_word), 64'h11);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("abort step", 64'(bus.step_count), 64'h0);
        checkOutput("abort vector", 64'(bus.vector_operations), 64'b11000);

        runIdle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        runIdle(7);
        checkOutput("overrun w6", 64'(bus.ctrl_word), 64'h46);
        checkOutput("overrun err early", 64'(bus.ucode_err), 64'h0);
        runIdle(1);
        checkOutput("overrun w7", 64'(bus.ctrl_word), 64'h47);
        checkOutput("overrun done", 64'(bus.instr_done), 64'h1);
        checkOutput("overrun err", 64'(bus.ucode_err), 64'h1);
        runIdle(2);
        checkOutput("err sticky", 64'(bus.ucode_err), 64'h1);

        nmi_lvl = 1'b0;
        irq_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) nmi_lvl = ~nmi_lvl;
            if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
                          8'($urandom), nmi_lvl, irq_lvl, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
